// File: rtl/fp_mul_mant_norm.sv
// Mantissa multiply, normalize and round stage of the FP32 multiplier.
// Accepts operands plus the pre-biased exponent from fp_mul_exp. A radix-2 shift-add
// multiplier runs for one cycle per multiplier bit. The product is then normalized,
// rounded to nearest-even and range-checked, and the packed result is held until the
// downstream handshake completes.
module fp_mul_mant_norm #(
  parameter int unsigned FpWidth   = 32,
  parameter int unsigned ExpWidth  = 8,
  parameter int unsigned MantWidth = 23
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [FpWidth-1:0]  mul1_i,
  input  logic [FpWidth-1:0]  mul2_i,
  input  logic [ExpWidth-1:0] exp_in_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [FpWidth-1:0]  result_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int unsigned SigWidth  = MantWidth + 1;
  localparam int unsigned ProdWidth = 2 * SigWidth;
  localparam int unsigned CntWidth  = $clog2(SigWidth);
  // Two extra bits hold the unbiased-sum range (-125..382) as a signed value.
  localparam int unsigned EWidth    = ExpWidth + 2;

  localparam logic [CntWidth-1:0]      LastCnt = CntWidth'(SigWidth - 1);
  localparam logic [EWidth-1:0]        Bias    = EWidth'((1 << (ExpWidth - 1)) - 1);
  localparam logic [ExpWidth-1:0]      ExpMax  = '1;
  localparam logic signed [EWidth-1:0] EOvf    = EWidth'((1 << ExpWidth) - 1);

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;
  typedef enum logic [1:0] {ClsNormal, ClsNan, ClsInf, ClsZero} class_e;

  state_e state_q, state_d;

  logic                     sign_q, sign_d;
  logic [SigWidth-1:0]      mant_a_q, mant_a_d;
  logic [SigWidth-1:0]      mant_b_q, mant_b_d;
  logic [ExpWidth-1:0]      exp_in_q, exp_in_d;
  logic signed [EWidth-1:0] e_q, e_d;
  class_e                   cls_q, cls_d;
  logic [ProdWidth-1:0]     acc_q, acc_d;
  logic [CntWidth-1:0]      cnt_q, cnt_d;
  logic [FpWidth-1:0]       res_q, res_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  // Operand field decode, used only on the accept cycle.
  logic [ExpWidth-1:0]  exp_a, exp_b;
  logic [MantWidth-1:0] frac_a, frac_b;
  logic                 zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  class_e               in_cls;

  assign exp_a  = mul1_i[FpWidth-2 -: ExpWidth];
  assign exp_b  = mul2_i[FpWidth-2 -: ExpWidth];
  assign frac_a = mul1_i[MantWidth-1:0];
  assign frac_b = mul2_i[MantWidth-1:0];
  // Exponent zero covers both true zero and flushed subnormals.
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == ExpMax) && (frac_a == '0);
  assign inf_b  = (exp_b == ExpMax) && (frac_b == '0);
  assign nan_a  = (exp_a == ExpMax) && (frac_a != '0);
  assign nan_b  = (exp_b == ExpMax) && (frac_b != '0);

  // Classify the operand pair; NaN outranks Inf outranks zero.
  always_comb begin
    in_cls = ClsNormal;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      in_cls = ClsNan;
    end else if (inf_a || inf_b) begin
      in_cls = ClsInf;
    end else if (zero_a || zero_b) begin
      in_cls = ClsZero;
    end
  end

  // Normalize and round the finished product.
  logic                     prod_msb;
  logic [MantWidth-1:0]     frac_n;
  logic                     guard, sticky, round_up, carry;
  logic [SigWidth-1:0]      frac_sum;
  logic [MantWidth-1:0]     frac_r;
  logic signed [EWidth-1:0] e_r;
  logic [ExpWidth-1:0]      ef_r;

  assign prod_msb = acc_q[ProdWidth-1];
  assign frac_n   = prod_msb ? acc_q[ProdWidth-2 -: MantWidth] : acc_q[ProdWidth-3 -: MantWidth];
  assign guard    = prod_msb ? acc_q[SigWidth-1] : acc_q[SigWidth-2];
  assign sticky   = prod_msb ? (|acc_q[SigWidth-2:0]) : (|acc_q[SigWidth-3:0]);
  assign round_up = guard & (sticky | frac_n[0]);
  assign frac_sum = {1'b0, frac_n} + SigWidth'(round_up);
  // A carry out of the fraction leaves it all zeros and bumps the exponent.
  assign carry    = frac_sum[MantWidth];
  assign frac_r   = frac_sum[MantWidth-1:0];
  assign e_r      = e_q + EWidth'(prod_msb) + EWidth'(carry);
  assign ef_r     = exp_in_q + ExpWidth'(prod_msb) + ExpWidth'(carry);

  // Final result selection: specials first, then range checks, then the packed value.
  logic [FpWidth-1:0] norm_res;
  logic               norm_ovf, norm_unf;

  always_comb begin
    norm_res = {sign_q, ef_r, frac_r};
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    case (cls_q)
      ClsNan:  norm_res = {1'b0, ExpMax, 1'b1, (MantWidth - 1)'(0)};
      ClsInf:  norm_res = {sign_q, ExpMax, MantWidth'(0)};
      ClsZero: norm_res = {sign_q, (FpWidth - 1)'(0)};
      default: begin
        if (e_r >= EOvf) begin
          norm_res = {sign_q, ExpMax, MantWidth'(0)};
          norm_ovf = 1'b1;
        end else if (e_r[EWidth-1] || (e_r == '0)) begin
          norm_res = {sign_q, (FpWidth - 1)'(0)};
          norm_unf = 1'b1;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid_i) state_d = StMul;
      StMul:   if (cnt_q == LastCnt) state_d = StNorm;
      StNorm:  state_d = StDone;
      StDone:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);

  // Datapath next values: latch on accept, shift-add in MUL, capture result in NORM.
  always_comb begin
    sign_d   = sign_q;
    mant_a_d = mant_a_q;
    mant_b_d = mant_b_q;
    exp_in_d = exp_in_q;
    e_d      = e_q;
    cls_d    = cls_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          sign_d   = mul1_i[FpWidth-1] ^ mul2_i[FpWidth-1];
          mant_a_d = {1'b1, frac_a};
          mant_b_d = {1'b1, frac_b};
          exp_in_d = exp_in_i;
          e_d      = EWidth'(exp_a) + EWidth'(exp_b) - Bias;
          cls_d    = in_cls;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StMul: begin
        if (mant_b_q[cnt_q]) begin
          acc_d = acc_q + (ProdWidth'(mant_a_q) << cnt_q);
        end
        cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntWidth'(1);
      end
      StNorm: begin
        res_d = norm_res;
        ovf_d = norm_ovf;
        unf_d = norm_unf;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q   <= 1'b0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      exp_in_q <= '0;
      e_q      <= '0;
      cls_q    <= ClsNormal;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      sign_q   <= sign_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      exp_in_q <= exp_in_d;
      e_q      <= e_d;
      cls_q    <= cls_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign result_o    = res_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_fp_mul_mant_norm.sv
// Bench for fp_mul_mant_norm: an arithmetic FP32 multiply model feeds a scoreboard,
// and one compare process checks the held outputs on every cycle out_valid is high.
module tb_fp_mul_mant_norm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mul1 = '0;
  logic [31:0] mul2 = '0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // Expected {overflow, underflow, result} per accepted op.
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mul_mant_norm dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .mul1_i     (mul1),
    .mul2_i     (mul2),
    .exp_in_i   (exp_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .overflow_o (overflow),
    .underflow_o(underflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer product, remainder-vs-half rounding.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [7:0] ei);
    int ea, eb, e, sh;
    logic s, za, zb, ia, ib, na, nb;
    longint unsigned ma, mb, p, q, rem, half;
    logic [7:0] ef;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 23'h0);
    ib = (eb == 255) && (b[22:0] == 23'h0);
    na = (ea == 255) && (a[22:0] != 23'h0);
    nb = (eb == 255) && (b[22:0] != 23'h0);
    if (na || nb || (ia && zb) || (ib && za)) return {2'b00, 32'h7FC00000};
    if (ia || ib) return {2'b00, s, 8'hFF, 23'h0};
    if (za || zb) return {2'b00, s, 31'h0};
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    p  = ma * mb;
    sh = (p >= (64'd1 << 47)) ? 1 : 0;
    q    = p >> (23 + sh);
    rem  = p - (q << (23 + sh));
    half = 64'd1 << (22 + sh);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q  = 64'd1 << 23;
      sh = sh + 1;
    end
    e = ea + eb - 127 + sh;
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b01, s, 31'h0};
    ef = ei + 8'(sh);
    return {2'b00, s, ef, q[22:0]};
  endfunction

  // Compare process: outputs must match the oldest outstanding op while out_valid is high.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
      end else begin
        check("result", {30'b0, overflow, underflow, result}, {30'b0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] up_exp(input logic [31:0] a, input logic [31:0] b);
    return 8'(int'(a[30:23]) + int'(b[30:23]) - 127);
  endfunction

  // Present one op and return right after the accept edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [7:0] ei;
    ei = up_exp(a, b);
    n  = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_before_accept", {63'b0, in_ready}, 64'd1);
    mul1     = a;
    mul2     = b;
    exp_in   = ei;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b, ei));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mul1     = 32'hDEADBEEF;
    mul2     = 32'h12345678;
    exp_in   = 8'h5A;
    check("in_ready_after_accept", {63'b0, in_ready}, 64'd0);
  endtask

  // Wait for out_valid and check it arrives after exactly 25 more edges.
  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'd25);
  endtask

  // Full op with out_ready held high; checks the handshake releases the block.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit has_pin, input logic [33:0] pin);
    if (has_pin) check("model_pin", {30'b0, model(a, b, up_exp(a, b))}, {30'b0, pin});
    out_ready = 1'b1;
    accept(a, b);
    wait_out();
    @(posedge clk);
    #1;
    check("handshake_out_valid", {63'b0, out_valid}, 64'd0);
    check("handshake_in_ready", {63'b0, in_ready}, 64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          has_pin;
    logic [33:0] pin;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs = '{
      '{32'h3F800000, 32'h3F800000, 1'b1, {2'b00, 32'h3F800000}},
      '{32'h3FC00000, 32'h40000000, 1'b1, {2'b00, 32'h40400000}},
      '{32'h3FC00000, 32'h3FC00000, 1'b1, {2'b00, 32'h40100000}},
      '{32'h3F800001, 32'h3F800001, 1'b1, {2'b00, 32'h3F800002}},
      '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, {2'b00, 32'h407FFFFE}},
      '{32'h3F800001, 32'h3FC00000, 1'b1, {2'b00, 32'h3FC00002}},
      '{32'hC1200000, 32'h41200000, 1'b1, {2'b00, 32'hC2C80000}},
      '{32'h7F000000, 32'h40000000, 1'b1, {2'b10, 32'h7F800000}},
      '{32'h00800000, 32'h00800000, 1'b1, {2'b01, 32'h00000000}},
      '{32'hBF800000, 32'h00000000, 1'b1, {2'b00, 32'h80000000}},
      '{32'h7F800000, 32'h00000000, 1'b1, {2'b00, 32'h7FC00000}},
      '{32'hFF800000, 32'h40000000, 1'b1, {2'b00, 32'hFF800000}},
      '{32'h7FC00001, 32'h3F800000, 1'b1, {2'b00, 32'h7FC00000}},
      '{32'h40490FDB, 32'h402DF854, 1'b0, 34'h0},
      '{32'h3F3504F3, 32'h3F3504F4, 1'b0, 34'h0},
      '{32'h7F7FFFFF, 32'h3F800001, 1'b0, 34'h0},
      '{32'h80400000, 32'h3F000000, 1'b0, 34'h0}
    };

    // Reset values while rst_n is low.
    #1;
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_result", {30'b0, overflow, underflow, result}, 64'd0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].has_pin, vecs[i].pin);

    // Backpressure: result must stay put and a second request must be ignored.
    out_ready = 1'b0;
    accept(32'h40490FDB, 32'h40000000);
    wait_out();
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        mul1     = 32'h3F800000;
        mul2     = 32'h40400000;
        exp_in   = 8'h80;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
      check("bp_out_valid_held", {63'b0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", {63'b0, out_valid}, 64'd0);
    check("bp_release_in_ready", {63'b0, in_ready}, 64'd1);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("ignored_request_no_output", 64'(n), 64'd0);

    // Reset during MUL: in-flight op is discarded.
    accept(32'h3F800001, 32'h3FC00000);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    check("midreset_result", {30'b0, overflow, underflow, result}, 64'd0);
    check("midreset_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'h3F800001, 32'h3F800001, 1'b1, {2'b00, 32'h3F800002});

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_mant_norm.md
# fp_mul_mant_norm

Sequential mantissa-multiply, normalize and round stage of the FP32 multiplier. It sits directly downstream of `fp_mul_exp` and consumes its 8-bit `result_exp` on `exp_in`. It multiplies the two 24-bit significands with a radix-2 shift-add datapath, normalizes, and rounds to nearest-even. It then assembles the final IEEE-754 single-precision product behind a valid/ready handshake.

## Interface
- `FP_WIDTH`, 32, operand/result width
- `EXP_WIDTH`, 8, exponent field width
- `MANT_WIDTH`, 23, stored fraction width
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: operands and `exp_in` valid
- `in_ready` output 1: block can accept; high only in IDLE
- `mul1` input 32: operand A (same value driven into `fp_mul_exp`)
- `mul2` input 32: operand B
- `exp_in` input 8: `result_exp` from `fp_mul_exp`, i.e. (E1+E2-127) mod 256
- `out_valid` output 1: `result` valid
- `out_ready` input 1: downstream accepts `result`
- `result` output 32: FP32 product
- `overflow` output 1: result saturated to infinity
- `underflow` output 1: result flushed to zero

## Operation
- States: IDLE, MUL, NORM, DONE.
  - IDLE → MUL on `in_valid && in_ready`.
  - MUL → NORM after 24 iterations.
  - NORM → DONE after 1 cycle.
  - DONE → IDLE on `out_valid && out_ready`.
- **On accept, latch:**
  - sign = A[31]^B[31]
  - significands {1,frac} (24 bits each)
  - `exp_in`
  - 10-bit signed exponent e = E1+E2-127, computed internally for range checks only
  - special-case class
- **MUL:**
  - 48-bit accumulator P starts at 0; 5-bit counter counts 0..23.
  - Each cycle, add multiplicand<<count to P when multiplier bit[count]=1.
- **NORM:**
  - If P[47]=1: frac=P[46:24], guard=P[23], sticky=|P[22:0], e+=1, exp field = `exp_in`+1.
  - Else: frac=P[45:23], guard=P[22], sticky=|P[21:0], exp field = `exp_in`.
  - Round up iff guard && (sticky || frac[0]).
  - If rounding carries out of frac: frac=0, e+=1, exp field +=1.
- **Range checks (after rounding):**
  - e ≥ 255 → result = {sign, 8'hFF, 23'b0}, `overflow`=1.
  - e ≤ 0 → result = {sign, 31'b0}, `underflow`=1. No subnormal outputs.
- **Specials** (checked before range checks; they override the datapath and clear both flags):
  - Exponent 0 on any input means zero; subnormal inputs are flushed to zero.
  - Any NaN, or Inf×0 → 0x7FC00000.
  - Else any Inf → {sign, 8'hFF, 0}.
  - Else any zero → {sign, 31'b0}.
  - `exp_in` is ignored for specials.
- **Inputs while busy:** `mul1`, `mul2`, `exp_in` are don't-care outside the accept cycle. `in_valid` outside IDLE is ignored, with no queuing.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `result`=0, `overflow`=0, `underflow`=0, state IDLE, accumulator and counter 0.
- **Latency:**
  - Accept edge at cycle k.
  - MUL edges k+1..k+24.
  - NORM edge k+25.
  - `out_valid`=1 from cycle k+26, after edge k+25 registers the outputs.
  - Specials take the same fixed latency.
- **Throughput:** one op per ≥27 cycles. `in_ready` falls on the accept edge and rises on the edge that completes the output handshake. Accept and output never overlap.
- **Output hold:** `result`, `overflow`, `underflow` are registered and stable while `out_valid`=1 && `out_ready`=0. `out_valid` drops on the handshake edge. Outputs keep their last value after the handshake.
- **`out_ready` high early:** no effect before `out_valid`.
- **Reset mid-operation:** `rst_n` low in any state immediately returns all outputs to reset values. The in-flight op is discarded and never emitted.

## Test plan
- **Basic latency:** `mul1`=0x3F800000, `mul2`=0x3F800000, `exp_in`=0x7F, `out_ready`=1 → `result`=0x3F800000 exactly 26 cycles after accept; flags 0; `in_ready` high the following cycle.
- **Normalize shift:** 0x3FC00000 × 0x40000000, `exp_in`=0x80 → 0x40400000. Then 0x3FC00000 × 0x3FC00000, `exp_in`=0x7F → 0x40100000 (P[47]=1 path).
- **Rounding:** 0x3F800001 × 0x3F800001 → 0x3F800002. 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE.
- **Range:**
  - 0x7F000000 × 0x40000000 → 0x7F800000, `overflow`=1.
  - 0x00800000 × 0x00800000 → 0x00000000, `underflow`=1.
  - 0xBF800000 × 0x00000000 → 0x80000000, flags 0.
- **Specials:** 0x7F800000 × 0x00000000 → 0x7FC00000. 0xFF800000 × 0x40000000 → 0xFF800000. 0x7FC00001 × 0x3F800000 → 0x7FC00000.
- **Backpressure and reset:**
  - Hold `out_ready`=0 for 10 cycles after `out_valid` → `result` stable. A second `in_valid` pulse is ignored and `in_ready` stays 0.
  - Separately, assert `rst_n`=0 at MUL iteration 12 → `out_valid`=0, `result`=0, `in_ready`=1. The next op completes correctly.
